// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and count limits for the Gray counter and its bench.
// The conversion functions work on a zero-extended MAX_WIDTH word, so any narrower width fits.
package gray_pkg;

    localparam int MAX_WIDTH  = 32;
    localparam int GRAY_WIDTH = 4;

    localparam logic [GRAY_WIDTH-1:0] CNT_MAX = {GRAY_WIDTH{1'b1}};
    localparam logic [GRAY_WIDTH-1:0] CNT_MIN = '0;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero bits above the real MSB make b[MSB] = g[MSB] fall out of the same recurrence.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter_encoder.sv
// Combinational binary-to-Gray encoder that feeds the counter's Gray output register.
import gray_pkg::*;

module gray_encoder #(
    parameter int WIDTH = GRAY_WIDTH
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o = WIDTH'(bin2gray(MAX_WIDTH'(bin_i)));

endmodule

// File: rtl/gray_counter.sv
// Up/down counter with registered Gray and binary outputs, Gray-coded load and a
// terminal-count pulse; wraps or saturates at the limits depending on WRAP.
import gray_pkg::*;

module gray_counter #(
    parameter int WIDTH = GRAY_WIDTH,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             tc
);

    localparam logic [WIDTH-1:0] CNT_TOP = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_BOT = '0;
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             tc_q, tc_d;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (load) begin
            cnt_d = WIDTH'(gray2bin(MAX_WIDTH'(load_gray)));
        end else if (en) begin
            if (up) begin
                if (cnt_q == CNT_TOP) begin
                    tc_d  = 1'b1;
                    cnt_d = WRAP ? CNT_BOT : CNT_TOP;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else begin
                if (cnt_q == CNT_BOT) begin
                    tc_d  = 1'b1;
                    cnt_d = WRAP ? CNT_TOP : CNT_BOT;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
        end
    end

    // Encode the next count so Gray and binary outputs update on the same edge.
    gray_encoder #(
        .WIDTH (WIDTH)
    ) u_encoder (
        .bin_i  (cnt_d),
        .gray_o (gray_d)
    );

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            gray_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

    assign gray = gray_q;
    assign bin  = cnt_q;
    assign tc   = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: one wrapping and one saturating instance share stimulus.
`timescale 1ns/1ps
import gray_pkg::*;

module tb_gray_counter;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] gray;
        logic [W-1:0] bin;
        logic         tc;
        logic         step;
        logic         blocked;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, en, up, load;
    logic [W-1:0] load_gray;
    logic [W-1:0] gray_w, bin_w, gray_s, bin_s;
    logic         tc_w, tc_s;

    int checks = 0;
    int errors = 0;

    exp_t q_w[$];
    exp_t q_s[$];
    logic [W-1:0] m_cnt_w, m_cnt_s;
    logic [W-1:0] prev_gray_w, prev_gray_s;

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(W), .WRAP(1'b1)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .gray(gray_w), .bin(bin_w), .tc(tc_w)
    );

    gray_counter #(.WIDTH(W), .WRAP(1'b0)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .gray(gray_s), .bin(bin_s), .tc(tc_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference next state for one instance; gray is derived here, independently of the encoder.
    function automatic exp_t model(input logic [W-1:0] cnt, input bit wrap, input logic r,
                                   input logic e, input logic u, input logic l,
                                   input logic [W-1:0] lg);
        exp_t x;
        logic [W-1:0] n;
        x = '0;
        n = cnt;
        if (r) begin
            n = '0;
        end else if (l) begin
            n = W'(gray2bin(32'(lg)));
        end else if (e) begin
            x.step = 1'b1;
            if (u && cnt == CNT_MAX) begin
                x.tc = 1'b1;
                n = wrap ? CNT_MIN : CNT_MAX;
                x.blocked = !wrap;
            end else if (!u && cnt == CNT_MIN) begin
                x.tc = 1'b1;
                n = wrap ? CNT_MAX : CNT_MIN;
                x.blocked = !wrap;
            end else begin
                n = u ? cnt + 4'd1 : cnt - 4'd1;
            end
        end
        x.bin  = n;
        x.gray = n ^ (n >> 1);
        return x;
    endfunction

    task automatic step(input logic r, input logic e, input logic u, input logic l,
                        input logic [W-1:0] lg);
        exp_t xw, xs;
        @(negedge clk);
        rst = r; en = e; up = u; load = l; load_gray = lg;
        xw = model(m_cnt_w, 1'b1, r, e, u, l, lg);
        xs = model(m_cnt_s, 1'b0, r, e, u, l, lg);
        m_cnt_w = xw.bin;
        m_cnt_s = xs.bin;
        q_w.push_back(xw);
        q_s.push_back(xs);
        @(posedge clk);
        #1;
        check("sb_w_avail", 32'(q_w.size() > 0), 32'd1);
        check("sb_s_avail", 32'(q_s.size() > 0), 32'd1);
        if (q_w.size() > 0) begin
            xw = q_w.pop_front();
            check("wrap_gray", 32'(gray_w), 32'(xw.gray));
            check("wrap_bin",  32'(bin_w),  32'(xw.bin));
            check("wrap_tc",   32'(tc_w),   32'(xw.tc));
            if (xw.step) check("wrap_hamming", $countones(prev_gray_w ^ gray_w), 1);
        end
        if (q_s.size() > 0) begin
            xs = q_s.pop_front();
            check("sat_gray", 32'(gray_s), 32'(xs.gray));
            check("sat_bin",  32'(bin_s),  32'(xs.bin));
            check("sat_tc",   32'(tc_s),   32'(xs.tc));
            if (xs.step) check("sat_hamming", $countones(prev_gray_s ^ gray_s), xs.blocked ? 0 : 1);
        end
        prev_gray_w = gray_w;
        prev_gray_s = gray_s;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] up_seq [16];
        logic [W-1:0] rg;
        up_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                   4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_gray = '0;
        m_cnt_w = '0; m_cnt_s = '0; prev_gray_w = '0; prev_gray_s = '0;

        // Reset dominates a simultaneous load and enable.
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
        check("rst_gray", 32'(gray_w), 32'd0);
        check("rst_tc",   32'(tc_w),   32'd0);

        // Full up sweep: wrap instance returns to 0 with tc on the 16th step.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
            check("up_seq_gray", 32'(gray_w), 32'(up_seq[i]));
        end
        check("up_wrap_tc", 32'(tc_w), 32'd1);
        check("up_sat_hold", 32'(bin_s), 32'hf);

        // Down from 0 wraps to all-ones with tc, then steps normally.
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        check("dn_wrap_gray", 32'(gray_w), 32'b1000);
        check("dn_wrap_bin",  32'(bin_w),  32'b1111);
        check("dn_wrap_tc",   32'(tc_w),   32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        check("dn_next_gray", 32'(gray_w), 32'b1001);
        check("dn_next_tc",   32'(tc_w),   32'd0);

        // Load beats enable.
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110);
        check("load_bin", 32'(bin_w), 32'b0100);
        check("load_tc",  32'(tc_w),  32'd0);

        // Saturating instance holds at the top with tc every blocked cycle.
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
            check("sat_hold_gray", 32'(gray_s), 32'b1000);
            check("sat_hold_tc",   32'(tc_s),   32'd1);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        check("sat_rel_gray", 32'(gray_s), 32'b1001);
        check("sat_rel_tc",   32'(tc_s),   32'd0);

        // Reset in the middle of counting, then resume.
        step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0111);
        check("mid_bin", 32'(bin_w), 32'b0101);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        check("mid_rst_gray", 32'(gray_w), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
        check("mid_resume_gray", 32'(gray_w), 32'b0001);

        // Mixed traffic; the scoreboard and Hamming checks cover every cycle.
        for (int i = 0; i < 60; i++) begin
            rg = W'($urandom_range(0, 15));
            step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) == 0, rg);
        end

        check("sb_w_drained", q_w.size(), 0);
        check("sb_s_drained", q_s.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
